// File: rtl/mant_mul_seq_if.sv
// Operand/product handshake bundle for the sequential mantissa multiplier.
`timescale 1ns/1ps
interface mant_mul_seq_if #(
  parameter int unsigned HW = 12
);
  localparam int unsigned OW = 2 * HW;
  localparam int unsigned PW = 4 * HW;

  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] in_a;
  logic [OW-1:0] in_b;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out_product;
  logic          busy;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_product, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_product, busy
  );
endinterface

// File: rtl/mant_mul_seq.sv
// Iterative 2HW x 2HW mantissa multiplier: one shared HW x HW multiplier, four partial products.
// Optional macro MUL_SEQ_ZERO_SKIP_EN: zero operands bypass the multiply and complete in one cycle.
`timescale 1ns/1ps
module mant_mul_seq #(
  parameter int unsigned HW = 12
) (
  input logic          clk,
  input logic          rst,
  mant_mul_seq_if.slave bus
);
  localparam int unsigned OW = 2 * HW;
  localparam int unsigned PW = 4 * HW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [HW-1:0] a_lo_q, a_lo_d;
  logic [HW-1:0] a_hi_q, a_hi_d;
  logic [HW-1:0] b_lo_q, b_lo_d;
  logic [HW-1:0] b_hi_q, b_hi_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] out_product_q, out_product_d;
  logic          out_valid_q, out_valid_d;
  logic          in_ready_q, in_ready_d;
  logic          busy_q, busy_d;

  logic [HW-1:0] op_x, op_y;
  logic [OW-1:0] pp;
  logic [PW-1:0] pp_sh;
  logic [PW-1:0] acc_sum;

  // Partial-product select and alignment for the current idx.
  always_comb begin
    op_x  = a_lo_q;
    op_y  = b_lo_q;
    pp_sh = '0;
    case (idx_q)
      2'd0: begin op_x = a_lo_q; op_y = b_lo_q; end
      2'd1: begin op_x = a_lo_q; op_y = b_hi_q; end
      2'd2: begin op_x = a_hi_q; op_y = b_lo_q; end
      default: begin op_x = a_hi_q; op_y = b_hi_q; end
    endcase
    pp = OW'(op_x) * OW'(op_y);
    case (idx_q)
      2'd0:    pp_sh = PW'(pp);
      2'd1,
      2'd2:    pp_sh = PW'(pp) << HW;
      default: pp_sh = PW'(pp) << (2 * HW);
    endcase
    acc_sum = acc_q + pp_sh;
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    a_lo_d        = a_lo_q;
    a_hi_d        = a_hi_q;
    b_lo_d        = b_lo_q;
    b_hi_d        = b_hi_q;
    acc_d         = acc_q;
    out_product_d = out_product_q;
    out_valid_d   = out_valid_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_lo_d  = bus.in_a[HW-1:0];
          a_hi_d  = bus.in_a[OW-1:HW];
          b_lo_d  = bus.in_b[HW-1:0];
          b_hi_d  = bus.in_b[OW-1:HW];
          acc_d   = '0;
          idx_d   = 2'd0;
          state_d = MUL;
`ifdef MUL_SEQ_ZERO_SKIP_EN
          if ((bus.in_a == '0) || (bus.in_b == '0)) begin
            out_product_d = '0;
            out_valid_d   = 1'b1;
            state_d       = DONE;
          end
`endif
        end
      end
      MUL: begin
        acc_d = acc_sum;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          out_product_d = acc_sum;
          out_valid_d   = 1'b1;
          state_d       = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Mirrors of the next state so in_ready/busy track state without extra delay.
    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= 2'd0;
      a_lo_q        <= '0;
      a_hi_q        <= '0;
      b_lo_q        <= '0;
      b_hi_q        <= '0;
      acc_q         <= '0;
      out_product_q <= '0;
      out_valid_q   <= 1'b0;
      in_ready_q    <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      a_lo_q        <= a_lo_d;
      a_hi_q        <= a_hi_d;
      b_lo_q        <= b_lo_d;
      b_hi_q        <= b_hi_d;
      acc_q         <= acc_d;
      out_product_q <= out_product_d;
      out_valid_q   <= out_valid_d;
      in_ready_q    <= in_ready_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_product = out_product_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_mant_mul_seq.sv
// Directed bench for mant_mul_seq: vector table plus backpressure, abort and back-to-back sequences.
`timescale 1ns/1ps
module tb_mant_mul_seq;
  localparam int unsigned HW = 12;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   edge_n;

  mant_mul_seq_if #(.HW(HW)) bus ();

  mant_mul_seq #(.HW(HW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [47:0] p;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int exp_latency(input logic [23:0] a, input logic [23:0] b);
`ifdef MUL_SEQ_ZERO_SKIP_EN
    if (a == 24'd0 || b == 24'd0) return 0;
`endif
    return 4;
  endfunction

  // One full operation with out_ready held high; checks latency, product, busy span and return to idle.
  task automatic do_op(input logic [23:0] a, input logic [23:0] b, input logic [47:0] p, input string nm);
    int lat;
    int busy_n;
    int el;
    el = exp_latency(a, b);
    @(negedge clk);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_valid = 1'b1;
    chk({nm, "_rdy_pre"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_a     = ~a;
    bus.in_b     = ~b;
    chk({nm, "_rdy_post"}, 64'(bus.in_ready), 64'd0);
    lat    = 0;
    busy_n = 0;
    while (!bus.out_valid && lat < 20) begin
      if (bus.busy) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
    if (bus.busy) busy_n++;
    chk({nm, "_lat"}, 64'(lat), 64'(el));
    chk({nm, "_prod"}, 64'(bus.out_product), 64'(p));
    chk({nm, "_busy"}, 64'(busy_n), 64'(el + 1));
    @(posedge clk); #1;
    chk({nm, "_ov_clr"}, 64'(bus.out_valid), 64'd0);
    chk({nm, "_rdy_idle"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    int stray;
    int n_acc;
    int n_out;
    int acc_t [2];
    logic [47:0] prod [2];

    vecs[0] = '{a: 24'h000003, b: 24'h000005, p: 48'h00000000000F};
    vecs[1] = '{a: 24'hFFFFFF, b: 24'hFFFFFF, p: 48'hFFFFFE000001};
    vecs[2] = '{a: 24'h800000, b: 24'hC00000, p: 48'h600000000000};
    vecs[3] = '{a: 24'h800000, b: 24'h800000, p: 48'h400000000000};
    vecs[4] = '{a: 24'h001001, b: 24'h001001, p: 48'h000001002001};
    vecs[5] = '{a: 24'hFFFFFF, b: 24'h000001, p: 48'h000000FFFFFF};
    vecs[6] = '{a: 24'h001000, b: 24'h001000, p: 48'h000001000000};
    vecs[7] = '{a: 24'h123456, b: 24'h000010, p: 48'h000001234560};
    vecs[8] = '{a: 24'h000000, b: 24'hABCDEF, p: 48'h000000000000};
    vecs[9] = '{a: 24'hFFF000, b: 24'h001000, p: 48'h000FFF000000};

    checks       = 0;
    failures     = 0;
    edge_n       = 0;
    clk          = 1'b0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_product", 64'(bus.out_product), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Junk operands without in_valid must not start anything.
    bus.in_a = 24'hABCDEF;
    bus.in_b = 24'h123456;
    repeat (3) @(posedge clk);
    #1;
    chk("novalid_busy", 64'(bus.busy), 64'd0);
    chk("novalid_rdy", 64'(bus.in_ready), 64'd1);

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
    end

    // Backpressure: product must hold while out_ready is low.
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_a      = 24'h800000;
    bus.in_b      = 24'hC00000;
    bus.in_valid  = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_a     = 24'h000001;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp_lat", 64'(lat), 64'd4);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold_ov%0d", i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("bp_hold_prod%0d", i), 64'(bus.out_product), 64'h600000000000);
      chk($sformatf("bp_hold_rdy%0d", i), 64'(bus.in_ready), 64'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_ov", 64'(bus.out_valid), 64'd0);
    chk("bp_release_rdy", 64'(bus.in_ready), 64'd1);
    chk("bp_release_busy", 64'(bus.busy), 64'd0);

    // Reset while the third partial product is pending.
    @(negedge clk);
    bus.in_a     = 24'h123456;
    bus.in_b     = 24'h654321;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_ov", 64'(bus.out_valid), 64'd0);
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_rdy", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    stray = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.out_valid) stray++;
    end
    chk("abort_no_ov", 64'(stray), 64'd0);
    do_op(24'h000002, 24'h000007, 48'h00000000000E, "abort_next");

    // Back-to-back with in_valid held high: accepts must be 6 edges apart.
    @(negedge clk);
    bus.in_a     = 24'h000100;
    bus.in_b     = 24'h000100;
    bus.in_valid = 1'b1;
    n_acc    = 0;
    n_out    = 0;
    acc_t[0] = 0;
    acc_t[1] = 0;
    prod[0]  = '0;
    prod[1]  = '0;
    for (int i = 0; i < 40 && n_out < 2; i++) begin
      if (bus.out_valid) begin
        prod[n_out] = bus.out_product;
        n_out++;
        if (n_out == 1) begin
          bus.in_a = 24'h001000;
          bus.in_b = 24'h000010;
        end
      end
      if (bus.in_ready && n_acc < 2) begin
        acc_t[n_acc] = edge_n + 1;
        n_acc++;
      end
      if (n_out < 2) @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("b2b_outs", 64'(n_out), 64'd2);
    chk("b2b_prod0", 64'(prod[0]), 64'h000000010000);
    chk("b2b_prod1", 64'(prod[1]), 64'h000000010000);
    chk("b2b_spacing", 64'(acc_t[1] - acc_t[0]), 64'd6);
    repeat (3) @(posedge clk);
    #1;
    chk("b2b_idle", 64'(bus.busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
